// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data_mem between a CPU port (0) and a
// debug/DMA port (1); one transaction at a time, out-of-range addresses trapped.
module data_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     ack0,
  output logic                     ack1,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(MEM_DEPTH);

  // Handshake: a port holds reqN with stable weN/addrN/wdataN until ackN; the
  // one-cycle ackN pulse marks rdata/err valid, and reqN must drop or change at
  // the edge that ends the ack cycle.
  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_gnt_q, last_gnt_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     oor_q, oor_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;

  logic                     gnt_port;
  logic [ADDRESS_WIDTH-1:0] sel_addr;

  // On a tie the port that did not win last time is served.
  assign gnt_port = (req0 && req1) ? ~last_gnt_q : req1;
  assign sel_addr = gnt_port ? addr1 : addr0;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d    = gnt_port;
          last_gnt_d = gnt_port;
          we_d       = gnt_port ? we1 : we0;
          addr_d     = sel_addr;
          wdata_d    = gnt_port ? wdata1 : wdata0;
          oor_d      = (sel_addr >= DEPTH_A);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = oor_q ? '0 : mem_rd;
        err_d   = oor_q;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  // rst gates the strobe directly so a reset landing in ACCESS never commits a write.
  assign mem_we    = (state_q == ACCESS) && we_q && !oor_q && !rst;
  assign mem_a     = addr_q;
  assign mem_wd    = wdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a transaction-level model predicts each ack
// (port, cycle, rdata, err) and each memory write; one negedge process compares.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  data_mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- data_mem stand-in ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 3) ? 32'h0000_0011 : 32'h1000_0000 + 32'(i);
  endfunction

  logic [31:0] mem [0:31];
  bit          mem_loaded = 1'b0;
  assign mem_rd = (mem_a < 32'd32) ? mem[mem_a[4:0]] : 32'h0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_we && mem_a < 32'd32) begin
      mem[mem_a[4:0]] <= mem_wd;
    end
  end

  // ---------------- model + scoreboard ----------------
  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } ack_t;
  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  ack_t        exp_q[$];
  wr_t         wexp_q[$];
  logic [31:0] ref_mem [0:31];
  bit          model_last = 1'b1;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One served transaction: reads see memory before the access, in-range writes commit
  // in the cycle before the ack, out-of-range accesses return 0 with err.
  task automatic model_txn(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_cyc);
    ack_t e;
    wr_t  w;
    bit   oor;
    oor     = (addr >= 32'd32);
    e.port  = port;
    e.err   = oor;
    e.rdata = oor ? 32'h0 : ref_mem[addr[4:0]];
    e.cyc   = ack_cyc;
    exp_q.push_back(e);
    if (we && !oor) begin
      ref_mem[addr[4:0]] = wdata;
      w.cyc = ack_cyc - 1;
      w.a   = addr;
      w.d   = wdata;
      wexp_q.push_back(w);
    end
    model_last = port;
  endtask

  always @(negedge clk) begin
    bit   exp_we;
    ack_t e;
    check_bit("ack_exclusive", ack0 & ack1, 1'b0);
    if (ack0 || ack1) begin
      if (exp_q.size() == 0) begin
        check_bit("unexpected_ack", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_bit("ack_port", ack1, e.port);
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("rdata", rdata, e.rdata);
        check_bit("err", err, e.err);
        last_rdata = rdata;
        last_err   = err;
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missing_ack_cycle", 32'(cyc), 32'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
    exp_we = (wexp_q.size() > 0) && (wexp_q[0].cyc == cyc);
    check_bit("mem_we", mem_we, exp_we);
    if (exp_we) begin
      check("mem_a", mem_a, wexp_q[0].a);
      check("mem_wd", mem_wd, wexp_q[0].d);
      void'(wexp_q.pop_front());
    end else if (wexp_q.size() > 0 && wexp_q[0].cyc < cyc) begin
      void'(wexp_q.pop_front());
    end
  end

  // ---------------- driver tasks (called just after a rising edge, arbiter idle) ----------------
  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int k;
    bit seen;
    k = cyc;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    model_txn(port, we, addr, wdata, k + 2);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) seen = 1'b1;
    end
    if (!seen) check_bit("ack_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // Both ports read addr continuously for n grants, then both drop.
  task automatic do_tie(input int n, input logic [31:0] addr);
    int t;
    bit p;
    t = cyc;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = addr; addr1 = addr; wdata0 = '0; wdata1 = '0;
    p = ~model_last;
    for (int i = 0; i < n; i++) begin
      model_txn(p, 1'b0, addr, 32'h0, t + 2 + 3 * i);
      p = ~p;
    end
    repeat (3 * n) @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    last_rdata = '0; last_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset then idle
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_bit("rst_ack0", ack0, 1'b0);
    check_bit("rst_ack1", ack1, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    @(posedge clk); #1;

    // tie from reset: port 0 first, then alternate
    do_tie(4, 32'd3);
    check("tie_rdata", last_rdata, 32'h11);

    // single write then read on port 0
    do_txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    do_txn(1'b0, 1'b0, 32'd5, 32'h0);
    check("rd5_literal", last_rdata, 32'hDEAD_BEEF);
    check_bit("rd5_err", last_err, 1'b0);

    // out of range write on port 1, then read of addr 0
    do_txn(1'b1, 1'b1, 32'd32, 32'h55);
    check_bit("oor_err", last_err, 1'b1);
    check("oor_rdata", last_rdata, 32'h0);
    do_txn(1'b1, 1'b0, 32'd0, 32'h0);
    check("rd0_literal", last_rdata, 32'h1000_0000);
    check_bit("rd0_err", last_err, 1'b0);

    // large address whose low bits alias word 5 must still be trapped
    do_txn(1'b0, 1'b1, 32'hFFFF_FFE5, 32'h1234_5678);
    do_txn(1'b0, 1'b0, 32'd5, 32'h0);
    check("alias_rd5", last_rdata, 32'hDEAD_BEEF);

    // last valid word
    do_txn(1'b1, 1'b1, 32'd31, 32'hCAFE_0031);
    do_txn(1'b0, 1'b0, 32'd31, 32'h0);
    check("rd31_literal", last_rdata, 32'hCAFE_0031);

    // reset during ACCESS of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'hA5;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req0 = 1'b0;
    model_last = 1'b1;
    check("midrst_state", 32'(dbg_state), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    do_txn(1'b0, 1'b0, 32'd7, 32'h0);
    check("midrst_rd7", last_rdata, 32'h1000_0007);

    // back-to-back same port
    do_txn(1'b0, 1'b1, 32'd2, 32'h1);
    do_txn(1'b0, 1'b0, 32'd2, 32'h0);
    check("b2b_rd2", last_rdata, 32'h1);

    // tie after a port-0 grant: port 1 goes first
    do_tie(2, 32'd31);
    check("tie2_rdata", last_rdata, 32'hCAFE_0031);

    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pending_acks", 32'(exp_q.size()), 32'h0);
    check("pending_writes", 32'(wexp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
